// File: rtl/md5_pad_stream_if.sv
// Stream bundle between a byte-oriented message source, md5_pad_stream and the
// MD5 compression core: beat input channel plus 512-bit block output channel.
interface md5_pad_stream_if #(
    parameter int IN_W = 32
) ();
    localparam int BYTES = IN_W / 8;
    localparam int BP_W  = $clog2(BYTES) + 1;

    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [BP_W-1:0] in_bytes;
    logic [511:0]    blk_data;
    logic            blk_valid;
    logic            blk_ready;
    logic            blk_first;
    logic            blk_last;

    // master: the environment (message source + block consumer); slave: the padder
    modport master (
        output in_data, in_valid, in_last, in_bytes, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_first, blk_last
    );

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, blk_ready,
        output in_ready, blk_data, blk_valid, blk_first, blk_last
    );
endinterface

// File: rtl/md5_pad_stream.sv
// Streaming MD5 padder/block framer: packs IN_W-bit beats into 512-bit blocks with
// 0x80 marker, zero fill and 64-bit bit length. Optional MD5_PAD_BE_EN adds be_mode.
module md5_pad_stream #(
    parameter int IN_W = 32
) (
    input  logic                in_clk,
    input  logic                reset,
    md5_pad_stream_if.slave     strm,
`ifdef MD5_PAD_BE_EN
    input  logic                be_mode,
`endif
    output logic                busy
);
    localparam int BYTES = IN_W / 8;
    localparam int BP_W  = $clog2(BYTES) + 1;
    localparam int WORDS = 512 / IN_W;
    localparam int PTR_W = $clog2(WORDS);
    localparam int BSH   = $clog2(BYTES);

    typedef enum logic [2:0] {
        ST_FILL       = 3'd0,
        ST_PAD        = 3'd1,
        ST_EMIT_MID   = 3'd2,
        ST_EMIT_EXTRA = 3'd3,
        ST_EMIT_FINAL = 3'd4,
        ST_LEN        = 3'd5
    } state_t;

    state_t             state_r;
    logic [511:0]       buf_r;
    logic [PTR_W-1:0]   ptr_r;
    logic [6:0]         byte_ptr_r;
    logic [60:0]        cnt_r;
    logic               first_pend_r;
    logic               pad_pend_r;
    logic               in_ready_r;
    logic               blk_valid_r;
    logic               blk_first_r;
    logic               blk_last_r;
    logic               busy_r;

    logic               acc_s;
    logic               hs_s;
    logic               be_eff_s;
    logic [BP_W-1:0]    nbytes_s;
    logic [5:0]         base_s;
    logic [6:0]         byte_ptr_s;
    logic [63:0]        len_s;
    logic [511:0]       beat_buf_s;
    logic [511:0]       mark_buf_s;

    function automatic logic [511:0] put_byte(input logic [511:0] blk, input logic [5:0] idx,
                                              input logic [7:0] val, input logic be);
        logic [511:0] res;
        logic [8:0]   pos;
        res = blk;
        if (be) begin
            pos = 9'd504 - {idx, 3'b000};
        end else begin
            pos = {idx, 3'b000};
        end
        res[pos +: 8] = val;
        return res;
    endfunction

    function automatic logic [511:0] put_len(input logic [511:0] blk, input logic [63:0] len,
                                             input logic be);
        logic [511:0] res;
        res = blk;
        if (be) begin
            res[63:0] = len;
        end else begin
            res[511:448] = len;
        end
        return res;
    endfunction

    assign acc_s      = strm.in_valid & in_ready_r;
    assign hs_s       = blk_valid_r & strm.blk_ready;
    assign base_s     = 6'(ptr_r) << BSH;
    assign byte_ptr_s = {1'b0, base_s} + 7'(nbytes_s);
    assign len_s      = {cnt_r, 3'b000};
    assign mark_buf_s = put_byte(buf_r, byte_ptr_r[5:0], 8'h80, be_eff_s);

`ifdef MD5_PAD_BE_EN
    logic be_r;

    // Byte order latched from the first beat of each message
    always_ff @(posedge in_clk) begin
        if (reset) begin
            be_r <= 1'b0;
        end else if (acc_s && !busy_r) begin
            be_r <= be_mode;
        end else begin
            be_r <= be_r;
        end
    end

    assign be_eff_s = busy_r ? be_r : be_mode;
`else
    assign be_eff_s = 1'b0;
`endif

    // Valid bytes in the current beat; oversize counts on a last beat are clamped
    always_comb begin
        if (!strm.in_last) begin
            nbytes_s = BP_W'(BYTES);
        end else if (strm.in_bytes > BP_W'(BYTES)) begin
            nbytes_s = BP_W'(BYTES);
        end else begin
            nbytes_s = strm.in_bytes;
        end
    end

    // Buffer image after writing the incoming beat, bytes past the count zeroed
    always_comb begin
        beat_buf_s = buf_r;
        for (int j = 0; j < BYTES; j++) begin
            if (BP_W'(j) < nbytes_s) begin
                beat_buf_s = put_byte(beat_buf_s, base_s + 6'(j), strm.in_data[8*j +: 8], be_eff_s);
            end else begin
                beat_buf_s = put_byte(beat_buf_s, base_s + 6'(j), 8'h00, be_eff_s);
            end
        end
    end

    // Framing FSM with registered handshake/status outputs
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_r      <= ST_FILL;
            buf_r        <= 512'd0;
            ptr_r        <= '0;
            byte_ptr_r   <= 7'd0;
            cnt_r        <= 61'd0;
            first_pend_r <= 1'b1;
            pad_pend_r   <= 1'b0;
            in_ready_r   <= 1'b1;
            blk_valid_r  <= 1'b0;
            blk_first_r  <= 1'b0;
            blk_last_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (acc_s) begin
                        buf_r  <= beat_buf_s;
                        cnt_r  <= cnt_r + 61'(nbytes_s);
                        busy_r <= 1'b1;
                        if (strm.in_last) begin
                            state_r    <= ST_PAD;
                            byte_ptr_r <= byte_ptr_s;
                            in_ready_r <= 1'b0;
                        end else if (ptr_r == PTR_W'(WORDS - 1)) begin
                            state_r     <= ST_EMIT_MID;
                            in_ready_r  <= 1'b0;
                            blk_valid_r <= 1'b1;
                            blk_first_r <= first_pend_r;
                        end else begin
                            ptr_r <= ptr_r + PTR_W'(1);
                        end
                    end
                end
                ST_PAD: begin
                    blk_valid_r <= 1'b1;
                    blk_first_r <= first_pend_r;
                    if (byte_ptr_r == 7'd64) begin
                        // Block is full of data: marker goes into a block of its own
                        state_r    <= ST_EMIT_MID;
                        pad_pend_r <= 1'b1;
                    end else if (byte_ptr_r <= 7'd55) begin
                        buf_r      <= put_len(mark_buf_s, len_s, be_eff_s);
                        state_r    <= ST_EMIT_FINAL;
                        blk_last_r <= 1'b1;
                    end else begin
                        buf_r   <= mark_buf_s;
                        state_r <= ST_EMIT_EXTRA;
                    end
                end
                ST_EMIT_MID, ST_EMIT_EXTRA, ST_EMIT_FINAL: begin
                    if (hs_s) begin
                        buf_r        <= 512'd0;
                        ptr_r        <= '0;
                        blk_valid_r  <= 1'b0;
                        blk_first_r  <= 1'b0;
                        blk_last_r   <= 1'b0;
                        first_pend_r <= 1'b0;
                        if (state_r == ST_EMIT_FINAL) begin
                            state_r      <= ST_FILL;
                            cnt_r        <= 61'd0;
                            first_pend_r <= 1'b1;
                            in_ready_r   <= 1'b1;
                            busy_r       <= 1'b0;
                        end else if (state_r == ST_EMIT_EXTRA) begin
                            state_r <= ST_LEN;
                        end else if (pad_pend_r) begin
                            state_r    <= ST_PAD;
                            pad_pend_r <= 1'b0;
                            byte_ptr_r <= 7'd0;
                        end else begin
                            state_r    <= ST_FILL;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                ST_LEN: begin
                    buf_r       <= put_len(buf_r, len_s, be_eff_s);
                    state_r     <= ST_EMIT_FINAL;
                    blk_valid_r <= 1'b1;
                    blk_first_r <= first_pend_r;
                    blk_last_r  <= 1'b1;
                end
                default: begin
                    state_r     <= ST_FILL;
                    buf_r       <= 512'd0;
                    ptr_r       <= '0;
                    in_ready_r  <= 1'b1;
                    blk_valid_r <= 1'b0;
                    blk_first_r <= 1'b0;
                    blk_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign strm.in_ready  = in_ready_r;
    assign strm.blk_data  = buf_r;
    assign strm.blk_valid = blk_valid_r;
    assign strm.blk_first = blk_first_r;
    assign strm.blk_last  = blk_last_r;
    assign busy           = busy_r;

endmodule
